// File: rtl/alu_secuencial.sv
// Sequential ALU with a ready/valid handshake. Single-cycle logic ops plus
// iterative shift-add multiply and restoring divide, one bit per cycle.
//
// state    | meaning
// INACTIVO | idle, listo=1, waiting for inicio
// CALCULO  | iterating MUL/DIVU/REMU, SIZEDATA cycles
// FIN      | result held, valido=1, waiting for acepta
module alu_secuencial #(
  parameter int SIZEDATA = 32,
  parameter int OP       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inicio,
  input  logic [SIZEDATA-1:0] a,
  input  logic [SIZEDATA-1:0] b,
  input  logic [OP-1:0]       operador,
  input  logic                acepta,
  output logic                listo,
  output logic                valido,
  output logic [SIZEDATA-1:0] resultado,
  output logic                zero,
  output logic                desborde,
  output logic                div0,
  output logic                invalido
);

  typedef enum logic [1:0] {INACTIVO, CALCULO, FIN} state_t;

  localparam int CW = (SIZEDATA > 1) ? $clog2(SIZEDATA) : 1;
  localparam logic [OP-1:0] OP_AND  = 'h0;
  localparam logic [OP-1:0] OP_OR   = 'h1;
  localparam logic [OP-1:0] OP_ADD  = 'h2;
  localparam logic [OP-1:0] OP_MUL  = 'h3;
  localparam logic [OP-1:0] OP_DIVU = 'h4;
  localparam logic [OP-1:0] OP_REMU = 'h5;
  localparam logic [OP-1:0] OP_SUB  = 'h6;
  localparam logic [OP-1:0] OP_SLT  = 'h7;
  localparam logic [OP-1:0] OP_NOR  = 'hC;

  state_t              state_q, state_d;
  logic [OP-1:0]       op_q, op_d;
  logic [SIZEDATA-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SIZEDATA-1:0] res_q, res_d;
  logic                zero_q, zero_d, ovf_q, ovf_d, d0_q, d0_d, inv_q, inv_d;

  logic [SIZEDATA-1:0] sc_res, sum, dif;
  logic                sc_ovf, sc_inv, is_multi;
  logic [SIZEDATA-1:0] mul_acc, rem_lo, div_rem, div_quo, iter_res;
  logic                div_ge;

  always_comb begin
    sum      = a + b;
    dif      = a - b;
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_inv   = 1'b0;
    is_multi = (operador == OP_MUL) || (operador == OP_DIVU) || (operador == OP_REMU);
    case (operador)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[SIZEDATA-1] == b[SIZEDATA-1]) && (sum[SIZEDATA-1] != a[SIZEDATA-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (a[SIZEDATA-1] != b[SIZEDATA-1]) && (dif[SIZEDATA-1] != a[SIZEDATA-1]);
      end
      OP_SLT:  sc_res = {{(SIZEDATA-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  sc_res = ~(a | b);
      OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
      default: sc_inv = 1'b1;
    endcase
  end

  // acc doubles as product accumulator or partial remainder; opa as
  // multiplicand or quotient shift register; opb as multiplier or divisor.
  always_comb begin
    mul_acc  = opb_q[0] ? (acc_q + opa_q) : acc_q;
    rem_lo   = {acc_q[SIZEDATA-2:0], opa_q[SIZEDATA-1]};
    div_ge   = acc_q[SIZEDATA-1] || (rem_lo >= opb_q);
    div_rem  = div_ge ? (rem_lo - opb_q) : rem_lo;
    div_quo  = {opa_q[SIZEDATA-2:0], div_ge};
    iter_res = (op_q == OP_MUL) ? mul_acc : ((op_q == OP_DIVU) ? div_quo : div_rem);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= INACTIVO;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INACTIVO: if (inicio) state_d = is_multi ? CALCULO : FIN;
      CALCULO:  if (cnt_q == '0) state_d = FIN;
      FIN:      if (acepta) state_d = INACTIVO;
      default:  state_d = INACTIVO;
    endcase
  end

  always_comb begin
    listo  = (state_q == INACTIVO);
    valido = (state_q == FIN);
  end

  always_comb begin
    op_d   = op_q;
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    d0_d   = d0_q;
    inv_d  = inv_q;
    case (state_q)
      INACTIVO: if (inicio) begin
        op_d  = operador;
        acc_d = '0;
        opa_d = a;
        opb_d = b;
        cnt_d = CW'(SIZEDATA - 1);
        if (!is_multi) begin
          res_d  = sc_res;
          zero_d = (sc_res == '0);
          ovf_d  = sc_ovf;
          d0_d   = 1'b0;
          inv_d  = sc_inv;
        end
      end
      CALCULO: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = div_rem;
          opa_d = div_quo;
        end
        if (cnt_q == '0) begin
          res_d  = iter_res;
          zero_d = (iter_res == '0);
          ovf_d  = 1'b0;
          inv_d  = 1'b0;
          d0_d   = (op_q != OP_MUL) && (opb_q == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      d0_q   <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      d0_q   <= d0_d;
      inv_q  <= inv_d;
    end
  end

  assign resultado = res_q;
  assign zero      = zero_q;
  assign desborde  = ovf_q;
  assign div0      = d0_q;
  assign invalido  = inv_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial: reference model results are queued
// at issue time and popped when valido rises.
module tb_alu_secuencial;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, inicio, acepta;
  logic [W-1:0] a, b;
  logic [3:0]   operador;
  logic         listo, valido, zero, desborde, div0, invalido;
  logic [W-1:0] resultado;

  alu_secuencial #(.SIZEDATA(W), .OP(4)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .a(a), .b(b), .operador(operador),
    .acepta(acepta), .listo(listo), .valido(valido), .resultado(resultado),
    .zero(zero), .desborde(desborde), .div0(div0), .invalido(invalido)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z, ovf, d0, inv;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0]  s;
    logic [63:0] p;
    e.res = '0; e.ovf = 0; e.d0 = 0; e.inv = 0; e.lat = 1;
    case (op)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin s = {x[W-1], x} + {y[W-1], y}; e.res = s[W-1:0]; e.ovf = s[W] ^ s[W-1]; end
      4'b0110: begin s = {x[W-1], x} - {y[W-1], y}; e.res = s[W-1:0]; e.ovf = s[W] ^ s[W-1]; end
      4'b0111: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(x | y);
      4'b0011: begin p = {32'd0, x} * {32'd0, y}; e.res = p[W-1:0]; e.lat = W + 1; end
      4'b0100: begin e.res = (y == 0) ? 32'hFFFF_FFFF : x / y; e.d0 = (y == 0); e.lat = W + 1; end
      4'b0101: begin e.res = (y == 0) ? x : x % y; e.d0 = (y == 0); e.lat = W + 1; end
      default: e.inv = 1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [W+3:0] outv();
    return {resultado, zero, desborde, div0, invalido};
  endfunction

  function automatic logic [W+3:0] expv(input exp_t e);
    return {e.res, e.z, e.ovf, e.d0, e.inv};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    operador = op; a = x; b = y; inicio = 1;
    exp_q.push_back(model(op, x, y));
    @(posedge clk);
    #1 inicio = 0; a = $urandom; b = $urandom; operador = 4'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (valido) begin lat = i; break; end
    end
  endtask

  task automatic consume();
    acepta = 1;
    @(posedge clk);
    #1 acepta = 0;
  endtask

  task automatic test_reset();
    rst = 1; inicio = 1; acepta = 0; operador = 4'b0010; a = 1; b = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({listo, valido} !== 2'b10) begin errors++; $display("FAIL reset_hs got %b want 10", {listo, valido}); end
    checks++;
    if (outv() !== {32'd0, 4'b1000}) begin errors++; $display("FAIL reset_out got %h want %h", outv(), {32'd0, 4'b1000}); end
    rst = 0; inicio = 0;
  endtask

  task automatic test_add_ovf();
    exp_t e; int lat;
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL add_lat got %0d want %0d", lat, e.lat); end
    checks++;
    if (outv() !== {32'h8000_0000, 4'b0100}) begin errors++; $display("FAIL add_ovf got %h want %h", outv(), {32'h8000_0000, 4'b0100}); end
    checks++;
    if (outv() !== expv(e)) begin errors++; $display("FAIL add_model got %h want %h", outv(), expv(e)); end
    consume();
  endtask

  task automatic test_sub_hold();
    exp_t e; int lat;
    issue(4'b0110, 32'd5, 32'd5);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL sub_lat got %0d want %0d", lat, e.lat); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valido, outv()} !== {1'b1, 32'd0, 4'b1000}) begin
        errors++; $display("FAIL sub_hold%0d got %h want %h", i, {valido, outv()}, {1'b1, 32'd0, 4'b1000});
      end
      if (i < 2) @(negedge clk);
    end
    consume();
    @(negedge clk);
    checks++;
    if ({listo, valido} !== 2'b10) begin errors++; $display("FAIL sub_release got %b want 10", {listo, valido}); end
  endtask

  task automatic test_mul();
    exp_t e; int lat;
    issue(4'b0011, 32'h0001_0000, 32'h0001_0001);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 10) begin
        checks++;
        if (listo !== 1'b0) begin errors++; $display("FAIL mul_busy got %b want 0", listo); end
        inicio = 1; a = 7; b = 9; operador = 4'b0010;
      end else inicio = 0;
      if (valido) begin lat = i; break; end
    end
    inicio = 0;
    e = exp_q.pop_front();
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mul_lat got %0d want 33", lat); end
    checks++;
    if (outv() !== {32'h0001_0000, 4'b0000}) begin errors++; $display("FAIL mul_res got %h want %h", outv(), {32'h0001_0000, 4'b0000}); end
    checks++;
    if (outv() !== expv(e)) begin errors++; $display("FAIL mul_model got %h want %h", outv(), expv(e)); end
    consume();
    issue(4'b0011, 32'hDEAD_BEEF, 32'h1234_5679);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if (outv() !== expv(e)) begin errors++; $display("FAIL mul_rand got %h want %h", outv(), expv(e)); end
    consume();
  endtask

  task automatic test_div();
    logic [3:0]   ops [4] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101};
    logic [W-1:0] xs  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
    logic [W-1:0] ys  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] rs  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    exp_t e; int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== W + 1) begin errors++; $display("FAIL div_lat%0d got %0d want %0d", i, lat, W + 1); end
      checks++;
      if ({resultado, div0} !== {rs[i], ys[i] == 0}) begin
        errors++; $display("FAIL div_res%0d got %h/%b want %h/%b", i, resultado, div0, rs[i], ys[i] == 0);
      end
      checks++;
      if (outv() !== expv(e)) begin errors++; $display("FAIL div_model%0d got %h want %h", i, outv(), expv(e)); end
      consume();
    end
  endtask

  task automatic test_misc();
    logic [3:0]   ops [6] = '{4'b0111, 4'b1100, 4'b1111, 4'b0000, 4'b0110, 4'b0001};
    logic [W-1:0] xs  [6] = '{32'hFFFF_FFFF, 32'd0, 32'h1234, 32'hF0F0_F0F0, 32'h8000_0000, 32'hA5A5_0000};
    logic [W-1:0] ys  [6] = '{32'd1, 32'd0, 32'h5678, 32'hFF00_FF00, 32'd1, 32'h0000_5A5A};
    logic [W-1:0] rs  [6] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'hF000_F000, 32'h7FFF_FFFF, 32'hA5A5_5A5A};
    exp_t e; int lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL misc_lat%0d got %0d want 1", i, lat); end
      checks++;
      if (resultado !== rs[i]) begin errors++; $display("FAIL misc_res%0d got %h want %h", i, resultado, rs[i]); end
      checks++;
      if (outv() !== expv(e)) begin errors++; $display("FAIL misc_model%0d got %h want %h", i, outv(), expv(e)); end
      consume();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat;
    issue(4'b0011, 32'h0000_0F0F, 32'h0000_0303);
    repeat (9) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++;
    if ({listo, valido, outv()} !== {2'b10, 32'd0, 4'b1000}) begin
      errors++; $display("FAIL rst_mid got %h want %h", {listo, valido, outv()}, {2'b10, 32'd0, 4'b1000});
    end
    issue(4'b0010, 32'd3, 32'd4);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 1 || outv() !== expv(e)) begin
      errors++; $display("FAIL rst_add got lat %0d %h want lat 1 %h", lat, outv(), expv(e));
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'h9};
    exp_t e; int lat;
    logic [W-1:0] x, y;
    acepta = 1;
    issue(4'b0000, 32'hFFFF_0000, 32'h0FF0_0FF0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({valido, outv()} !== {1'b1, expv(e)}) begin
      errors++; $display("FAIL early_acepta got %h want %h", {valido, outv()}, {1'b1, expv(e)});
    end
    @(posedge clk);
    #1 acepta = 0;
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(codes[$urandom_range(0, 9)], x, y);
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || outv() !== expv(e)) begin
        errors++; $display("FAIL b2b%0d got lat %0d %h want lat %0d %h", i, lat, outv(), e.lat, expv(e));
      end
      consume();
    end
  endtask

  initial begin
    rst = 1; inicio = 0; acepta = 0; a = 0; b = 0; operador = 0;
    test_reset();
    test_add_ovf();
    test_sub_hold();
    test_mul();
    test_div();
    test_misc();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
